// File: rtl/aes_pkg.sv
// AES-128 constants and GF(2^8) helpers shared by the iterative encryption core.
// Pure declarations: no logic, no latency, no flow control.
package aes_pkg;

   localparam int NB_ROUNDS = 10;

   typedef enum logic [1:0] {LOAD, ROUND, OUT} fsm_t;

   // Index 0 is the leftmost byte, so SBOX[x] is the forward S-box entry for x.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES-128 encryption round plus the matching key-schedule step, purely combinational.
// Zero latency; no flow control. MixColumns is bypassed when last=1.
module aes_round_comb
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rkey,
   input  logic [7:0]   rcon,
   input  logic         last,
   output logic [127:0] next_state,
   output logic [127:0] next_rkey
);

   logic [15:0][7:0] sb, sr, mc;
   logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = rkey;
   // SubWord(RotWord(w3)) with rcon folded into the top byte.
   assign t  = {SBOX[w3[23:16]] ^ rcon, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign next_rkey = {n0, n1, n2, n3};

   // Byte i is FIPS byte i (row i%4, column i/4), taken MSB-first from the 128-bit word.
   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      next_state = '0;
      for (int i = 0; i < 16; i++) sb[i] = SBOX[state[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
         mc[4*c]   = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
         mc[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
      end
      for (int i = 0; i < 16; i++)
         next_state[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ next_rkey[127-8*i -: 8];
   end

endmodule

// File: rtl/aes128_iter_stream.sv
// Iterative AES-128 encryptor: beat-serial key/plaintext in, 10 cycles of rounds, beat-serial ciphertext out.
// Output holds under out_ready=0; input closed until the last ciphertext beat leaves. AES_KEY_REUSE_EN adds key_keep.
module aes128_iter_stream
   import aes_pkg::*;
#(
   parameter int BUS_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BUS_W-1:0] in_key,
   input  logic [BUS_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BUS_W-1:0] out_data,
   output logic             busy
`ifdef AES_KEY_REUSE_EN
   ,
   input  logic             key_keep
`endif
);

   localparam int BEATS = 128 / BUS_W;

   if (!(BUS_W == 8 || BUS_W == 16 || BUS_W == 32 || BUS_W == 64 || BUS_W == 128)) begin : g_bad_bus_w
      $error("aes128_iter_stream: illegal BUS_W %0d", BUS_W);
   end

   fsm_t         fsm;
   logic [4:0]   beat_cnt;
   logic [3:0]   rnd;
   logic [127:0] key_sr, pt_sr, state, rkey;
   logic [127:0] key_full, pt_full, blk_key, next_state, next_rkey;
   logic [7:0]   rcon;
   logic         last_beat;

   assign key_full  = (key_sr << BUS_W) | 128'(in_key);
   assign pt_full   = (pt_sr << BUS_W) | 128'(in_data);
   assign last_beat = (beat_cnt == 5'(BEATS - 1));
   assign rcon      = (rnd >= 4'd1 && rnd <= 4'd10) ? RCON[rnd - 4'd1] : 8'h00;
   assign out_data  = state[127 -: BUS_W];

`ifdef AES_KEY_REUSE_EN
   logic         keep_flag;
   logic         use_keep;
   logic [127:0] kept_key;

   // On the first beat the live key_keep decides; later beats use the latched copy.
   assign use_keep = (beat_cnt == 5'd0) ? key_keep : keep_flag;
   assign blk_key  = use_keep ? kept_key : key_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         keep_flag <= 1'b0;
         kept_key  <= '0;
      end else if (fsm == LOAD && in_valid) begin
         if (beat_cnt == 5'd0) keep_flag <= key_keep;
         if (last_beat) kept_key <= blk_key;
      end
   end
`else
   assign blk_key = key_full;
`endif

   aes_round_comb u_round (
      .state      (state),
      .rkey       (rkey),
      .rcon       (rcon),
      .last       (rnd == 4'(NB_ROUNDS)),
      .next_state (next_state),
      .next_rkey  (next_rkey)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= LOAD;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         beat_cnt  <= '0;
         rnd       <= '0;
         key_sr    <= '0;
         pt_sr     <= '0;
         state     <= '0;
         rkey      <= '0;
      end else begin
         case (fsm)
            LOAD: if (in_valid) begin
               key_sr <= key_full;
               pt_sr  <= pt_full;
               if (last_beat) begin
                  state    <= pt_full ^ blk_key;
                  rkey     <= blk_key;
                  rnd      <= 4'd1;
                  beat_cnt <= '0;
                  fsm      <= ROUND;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  beat_cnt <= beat_cnt + 5'd1;
               end
            end
            ROUND: begin
               state <= next_state;
               rkey  <= next_rkey;
               if (rnd == 4'(NB_ROUNDS)) begin
                  fsm       <= OUT;
                  out_valid <= 1'b1;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            OUT: if (out_ready) begin
               state <= state << BUS_W;
               if (last_beat) begin
                  beat_cnt  <= '0;
                  rnd       <= '0;
                  fsm       <= LOAD;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end else begin
                  beat_cnt <= beat_cnt + 5'd1;
               end
            end
            default: fsm <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_iter_stream.sv
// Directed FIPS-197 vectors driven through four bus widths in parallel lanes.
`timescale 1ns/1ps
module tb_aes128_iter_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : lane
      localparam int W  = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 32 : 128;
      localparam int NB = 128 / W;

      logic         rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
      logic         in_ready, out_valid, busy;
      logic [W-1:0] in_key = '0, in_data = '0, out_data;
      bit           fin = 1'b0;
`ifdef AES_KEY_REUSE_EN
      logic         key_keep = 1'b0;
`endif

      aes128_iter_stream #(.BUS_W(W)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_key    (in_key),
         .in_data   (in_data),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_data  (out_data),
         .busy      (busy)
`ifdef AES_KEY_REUSE_EN
         ,
         .key_keep  (key_keep)
`endif
      );

      function automatic string tg(input string s);
         return $sformatf("w%0d_%s", W, s);
      endfunction

      task automatic step();
         @(posedge clk);
         #1;
      endtask

      task automatic send(input logic [127:0] key, input logic [127:0] pt, input int nbeats, input bit gaps);
         for (int b = 0; b < nbeats; b++) begin
            int  guard = 0;
            bit  acc;
            if (gaps) begin
               in_valid = 1'b0;
               repeat ($urandom_range(0, 2)) step();
            end
            in_valid = 1'b1;
            in_key   = key[127-b*W -: W];
            in_data  = pt[127-b*W -: W];
            do begin
               acc = in_ready;
               step();
               guard++;
            end while (!acc && guard < 200);
            if (!acc) check(tg("accept_timeout"), 128'(acc), 128'(1));
         end
         in_valid = 1'b0;
      endtask

      // Entered one step after the last input beat was accepted.
      task automatic latency(input bit junk);
         int lat = 0;
         check(tg("ready_low_round"), 128'(in_ready), 128'(0));
         check(tg("busy_round"), 128'(busy), 128'(1));
         while (!out_valid && lat < 40) begin
            if (junk) begin
               in_valid = lat[0];
               in_key   = '1;
               in_data  = '1;
            end
            step();
            lat++;
         end
         in_valid = 1'b0;
         check(tg("latency"), 128'(lat), 128'(10));
      endtask

      task automatic recv(input logic [127:0] exp_ct, input bit bp, input string name);
         logic [127:0] ct = '0;
         logic [W-1:0] held = '0;
         bit           stalled = 1'b0;
         int           b = 0, guard = 0;
         while (b < NB && guard < 500) begin
            out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (stalled) begin
               check(tg("stall_valid"), 128'(out_valid), 128'(1));
               check(tg("stall_data"), 128'(out_data), 128'(held));
            end
            check(tg("ready_low_out"), 128'(in_ready), 128'(0));
            held = out_data;
            if (out_valid && out_ready) begin
               ct = (ct << W) | 128'(out_data);
               b++;
               stalled = 1'b0;
            end else begin
               stalled = out_valid;
            end
            step();
            guard++;
         end
         out_ready = 1'b0;
         check(tg({name, "_beats"}), 128'(b), 128'(NB));
         check(tg({name, "_ct"}), ct, exp_ct);
         check(tg("valid_low_after"), 128'(out_valid), 128'(0));
         check(tg("ready_high_after"), 128'(in_ready), 128'(1));
      endtask

      initial begin
         step();
         step();
         rst = 1'b0;
         check(tg("rst_in_ready"), 128'(in_ready), 128'(1));
         check(tg("rst_out_valid"), 128'(out_valid), 128'(0));
         check(tg("rst_busy"), 128'(busy), 128'(0));
         check(tg("rst_out_data"), 128'(out_data), 128'(0));

         send(KEY_C, PT_C, NB, 1'b0);
         latency(1'b0);
         recv(CT_C, 1'b0, "c1");

         send(KEY_B, PT_B, NB, 1'b0);
         latency(1'b0);
         recv(CT_B, 1'b1, "b_bp");

         send(KEY_C, PT_C, NB, 1'b1);
         latency(1'b1);
         recv(CT_C, 1'b0, "c1_gaps");

         // Abort a partially loaded block, then a block stopped mid-round.
         send(KEY_B, PT_B, NB / 2, 1'b0);
         rst = 1'b1;
         step();
         rst = 1'b0;
         check(tg("abort_load_ready"), 128'(in_ready), 128'(1));
         send(KEY_B, PT_B, NB, 1'b0);
         repeat (4) step();
         check(tg("mid_round_busy"), 128'(busy), 128'(1));
         rst = 1'b1;
         step();
         rst = 1'b0;
         check(tg("abort_rnd_ready"), 128'(in_ready), 128'(1));
         check(tg("abort_rnd_busy"), 128'(busy), 128'(0));
         check(tg("abort_rnd_data"), 128'(out_data), 128'(0));
         send(KEY_C, PT_C, NB, 1'b0);
         latency(1'b0);
         recv(CT_C, 1'b1, "c1_after_rst");

`ifdef AES_KEY_REUSE_EN
         key_keep = 1'b0;
         send(KEY_B, PT_B, NB, 1'b0);
         latency(1'b0);
         recv(CT_B, 1'b0, "reuse_load");
         key_keep = 1'b1;
         send({128{1'b1}}, PT_B, NB, 1'b0);
         key_keep = 1'b0;
         latency(1'b0);
         recv(CT_B, 1'b0, "reuse_keep");
`endif
         fin = 1'b1;
      end
   end

   initial begin
      int cyc = 0;
      while (!(lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin) && cyc < 60000) begin
         @(posedge clk);
         cyc++;
      end
      check("all_lanes_done", 128'({lane[0].fin, lane[1].fin, lane[2].fin, lane[3].fin}), 128'(4'hf));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
